sine_meas: RTL and testbench



---
 rtl/sine_meas_pkg.sv | 24 ++
 rtl/sine_meas_zc_detect.sv | 53 +++++
 rtl/sine_meas.sv | 146 ++++++++++++++
 tb/tb_sine_meas.sv | 197 +++++++++++++++++++
 4 files changed

// File: rtl/sine_meas_pkg.sv
// Shared types and constants for the sine measurement block.
// SINE_MEAS_HYST_EN selects hysteretic crossing detection in zc_detect.
package sine_meas_pkg;

  typedef enum logic [0:0] {
    IDLE    = 1'b0,
    MEASURE = 1'b1
  } state_t;

  localparam int unsigned CNT_W_DEF = 32'd16;

  // Mid-level of an offset-binary sample of the given width.
  function automatic int unsigned mid_of(input int unsigned width);
    return 32'd1 << (width - 32'd1);
  endfunction

  // Largest sample index before a measurement is abandoned.
  function automatic int unsigned timeout_of(input int unsigned cnt_w);
    return (32'd1 << cnt_w) - 32'd1;
  endfunction

  localparam int unsigned TIMEOUT_DEF = timeout_of(CNT_W_DEF);

endpackage

// File: rtl/sine_meas_zc_detect.sv
// Rising mid-level crossing detector for one sample channel.
// With SINE_MEAS_HYST_EN defined the channel arms only below MID-HYST.
module zc_detect
  import sine_meas_pkg::*;
#(
  parameter int WIDTH = 8,
  parameter int HYST  = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             clr,
  input  logic             en,
  input  logic [WIDTH-1:0] din,
  output logic             xing
);

`ifdef SINE_MEAS_HYST_EN
  localparam bit HYST_ON = 1'b1;
`else
  localparam bit HYST_ON = 1'b0;
`endif

  localparam int ARM_DEPTH = HYST_ON ? HYST : 0;
  localparam logic [WIDTH-1:0] MID_LVL = WIDTH'(mid_of(WIDTH));
  localparam logic [WIDTH-1:0] ARM_LVL = WIDTH'(mid_of(WIDTH) - ARM_DEPTH);

  // With zero depth, armed_r means "the previous valid sample was below MID",
  // which is exactly the plain previous/current comparison.
  logic armed_r;
  logic below_s;
  logic above_s;

  // Level compares and en-qualified crossing flag.
  always_comb begin
    below_s = (din < ARM_LVL);
    above_s = (din >= MID_LVL);
    xing    = en & armed_r & above_s;
  end

  // Arm below the arm level; a crossing consumes the arm.
  always_ff @(posedge clk) begin
    if (rst || clr) begin
      armed_r <= 1'b0;
    end else if (en && below_s) begin
      armed_r <= 1'b1;
    end else if (xing) begin
      armed_r <= 1'b0;
    end else begin
      armed_r <= armed_r;
    end
  end

endmodule

// File: rtl/sine_meas.sv
// Measures ch0 period and ch1 lag (in samples) from two offset-binary sines.
// Optional hysteresis: define SINE_MEAS_HYST_EN.
module sine_meas
  import sine_meas_pkg::*;
#(
  parameter int WIDTH = 8,
  parameter int CNT_W = 16,
  parameter int HYST  = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en,
  input  logic [WIDTH-1:0] din,
  input  logic [WIDTH-1:0] din2,
  output logic [CNT_W-1:0] period,
  output logic [CNT_W-1:0] lag,
  output logic             lag_ok,
  output logic             valid,
  output logic             locked
);

  localparam logic [CNT_W-1:0] S_MAX = CNT_W'(timeout_of(CNT_W));

  state_t           state_r;
  state_t           state_nx_s;
  logic             x0_s;
  logic             x1_s;
  logic             start_s;
  logic             close_s;
  logic             tmo_s;
  logic [CNT_W-1:0] s_r;
  logic [CNT_W-1:0] lag_cap_r;
  logic             lag_seen_r;
  logic [CNT_W-1:0] period_r;
  logic [CNT_W-1:0] lag_r;
  logic             lag_ok_r;
  logic             valid_r;
  logic             locked_r;

  zc_detect #(.WIDTH(WIDTH), .HYST(HYST)) u_zc0 (
    .clk  (clk),
    .rst  (rst),
    .clr  (tmo_s),
    .en   (en),
    .din  (din),
    .xing (x0_s)
  );

  zc_detect #(.WIDTH(WIDTH), .HYST(HYST)) u_zc1 (
    .clk  (clk),
    .rst  (rst),
    .clr  (tmo_s),
    .en   (en),
    .din  (din2),
    .xing (x1_s)
  );

  // State register.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r <= IDLE;
    end else begin
      state_r <= state_nx_s;
    end
  end

  // Next state plus period start/close and timeout decisions.
  always_comb begin
    state_nx_s = state_r;
    start_s    = 1'b0;
    close_s    = 1'b0;
    tmo_s      = 1'b0;
    case (state_r)
      IDLE: begin
        if (x0_s) begin
          state_nx_s = MEASURE;
          start_s    = 1'b1;
        end else begin
          state_nx_s = IDLE;
        end
      end
      MEASURE: begin
        if (x0_s) begin
          state_nx_s = MEASURE;
          start_s    = 1'b1;
          close_s    = 1'b1;
        end else if (en && (s_r == S_MAX)) begin
          state_nx_s = IDLE;
          tmo_s      = 1'b1;
        end else begin
          state_nx_s = MEASURE;
        end
      end
      default: begin
        state_nx_s = IDLE;
      end
    endcase
  end

  // Sample index, lag capture and registered results.
  // A ch1 crossing on the same sample as a ch0 crossing opens the new period at k=0.
  always_ff @(posedge clk) begin
    if (rst) begin
      s_r        <= {CNT_W{1'b0}};
      lag_cap_r  <= {CNT_W{1'b0}};
      lag_seen_r <= 1'b0;
      period_r   <= {CNT_W{1'b0}};
      lag_r      <= {CNT_W{1'b0}};
      lag_ok_r   <= 1'b0;
      valid_r    <= 1'b0;
      locked_r   <= 1'b0;
    end else begin
      valid_r <= 1'b0;
      if (tmo_s) begin
        s_r        <= {CNT_W{1'b0}};
        lag_cap_r  <= {CNT_W{1'b0}};
        lag_seen_r <= 1'b0;
        locked_r   <= 1'b0;
      end else if (start_s) begin
        s_r        <= CNT_W'(1);
        lag_cap_r  <= {CNT_W{1'b0}};
        lag_seen_r <= x1_s;
        if (close_s) begin
          period_r <= s_r;
          lag_r    <= lag_cap_r;
          lag_ok_r <= lag_seen_r;
          valid_r  <= 1'b1;
          locked_r <= 1'b1;
        end
      end else if (en && (state_r == MEASURE)) begin
        s_r <= s_r + CNT_W'(1);
        if (x1_s && !lag_seen_r) begin
          lag_cap_r  <= s_r;
          lag_seen_r <= 1'b1;
        end
      end
    end
  end

  assign period = period_r;
  assign lag    = lag_r;
  assign lag_ok = lag_ok_r;
  assign valid  = valid_r;
  assign locked = locked_r;

endmodule

// File: tb/tb_sine_meas.sv
// Scoreboard bench for sine_meas: stimulus pushes expected results, a monitor
// pops and compares on every valid pulse. Build with SINE_MEAS_HYST_EN for hysteresis.
module tb_sine_meas;

  localparam int WIDTH = 8;
  localparam int CNT_W = 8;
  localparam int HYST  = 8;
  localparam real PI   = 3.14159265358979;

  logic             clk = 1'b0;
  logic             rst;
  logic             en;
  logic [WIDTH-1:0] din;
  logic [WIDTH-1:0] din2;
  logic [CNT_W-1:0] period;
  logic [CNT_W-1:0] lag;
  logic             lag_ok;
  logic             valid;
  logic             locked;

  typedef struct {
    int cyc;
    int period;
    int lag;
    int ok;
  } exp_t;

  exp_t q[$];
  int   tests = 0;
  int   fails = 0;
  int   cyc   = 0;

  sine_meas #(.WIDTH(WIDTH), .CNT_W(CNT_W), .HYST(HYST)) dut (
    .clk    (clk),
    .rst    (rst),
    .en     (en),
    .din    (din),
    .din2   (din2),
    .period (period),
    .lag    (lag),
    .lag_ok (lag_ok),
    .valid  (valid),
    .locked (locked)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // 64-sample sine, amplitude 100 around 128; the only rising crossing is at k=0.
  function automatic logic [7:0] wave(input int i);
    int  k;
    real r;
    k = ((i % 64) + 64) % 64;
    r = 128.0 + 100.0 * $sin(2.0 * PI * k / 64.0);
    return 8'(int'(r));
  endfunction

  // Sine with 0x7F/0x80 chatter at positions 20..23 of each period.
  function automatic logic [7:0] chat(input int i);
    int k;
    k = i % 64;
    if (k == 20 || k == 22) return 8'h7F;
    else if (k == 21 || k == 23) return 8'h80;
    else return wave(i);
  endfunction

  task automatic check(input string name, input int act, input int exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  task automatic step(input bit e, input logic [7:0] a, input logic [7:0] b);
    @(negedge clk);
    en   = e;
    din  = a;
    din2 = b;
    @(posedge clk);
    #1;
  endtask

  task automatic samp(input logic [7:0] a, input logic [7:0] b, input bit ev,
                      input int p, input int l, input int ok);
    exp_t e;
    step(1'b1, a, b);
    if (ev) begin
      e.cyc = cyc; e.period = p; e.lag = l; e.ok = ok;
      q.push_back(e);
    end
  endtask

  task automatic do_reset(input string tag);
    @(negedge clk);
    rst = 1'b1; en = 1'b1; din = 8'h80; din2 = 8'h80;
    @(posedge clk);
    #1;
    rst = 1'b0;
    check({tag, "_period"}, int'(period), 0);
    check({tag, "_lag"}, int'(lag), 0);
    check({tag, "_lag_ok"}, int'(lag_ok), 0);
    check({tag, "_valid"}, int'(valid), 0);
    check({tag, "_locked"}, int'(locked), 0);
  endtask

  // Monitor: every valid pulse must match the head of the scoreboard.
  always @(negedge clk) begin
    exp_t e;
    if (valid === 1'b1) begin
      if (q.size() == 0) begin
        tests++;
        fails++;
        $display("FAIL unexpected_valid: at cycle %0d period=%0d lag=%0d, expected no pulse",
                 cyc, period, lag);
      end else begin
        e = q.pop_front();
        check("valid_cycle", cyc, e.cyc);
        check("period", int'(period), e.period);
        check("lag", int'(lag), e.lag);
        check("lag_ok", int'(lag_ok), e.ok);
        check("locked_on_valid", int'(locked), 1);
      end
    end
  end

  initial begin
    rst = 1'b1; en = 1'b0; din = 8'h00; din2 = 8'h00;
    repeat (2) @(posedge clk);

    // ch1 lags 16 samples, en every clock.
    do_reset("rst_a");
    for (int i = 1; i <= 192; i++)
      samp(wave(i), wave(i - 16), (i >= 128) && (i % 64 == 0), 64, 16, 1);

    // Same stream, en every third clock: valids 192 clocks apart.
    do_reset("rst_b");
    for (int i = 1; i <= 192; i++) begin
      samp(wave(i), wave(i - 16), (i >= 128) && (i % 64 == 0), 64, 16, 1);
      step(1'b0, 8'h00, 8'hFF);
      step(1'b0, 8'h00, 8'hFF);
    end

    // ch1 identical to ch0: lag 0 belongs to the new period.
    do_reset("rst_c");
    for (int i = 1; i <= 128; i++)
      samp(wave(i), wave(i), i == 128, 64, 0, 1);

    // ch1 constant below MID: no lag.
    do_reset("rst_d");
    for (int i = 1; i <= 128; i++)
      samp(wave(i), 8'h40, i == 128, 64, 0, 0);

    // Timeout: din stuck at MID after lock.
    do_reset("rst_e");
    for (int i = 1; i <= 128; i++)
      samp(wave(i), wave(i - 16), i == 128, 64, 16, 1);
    for (int j = 0; j < 254; j++)
      samp(8'h80, 8'h40, 1'b0, 0, 0, 0);
    check("locked_before_timeout", int'(locked), 1);
    samp(8'h80, 8'h40, 1'b0, 0, 0, 0);
    check("locked_after_timeout", int'(locked), 0);
    check("period_hold_timeout", int'(period), 64);
    check("lag_hold_timeout", int'(lag), 16);
    for (int i = 1; i <= 128; i++)
      samp(wave(i), wave(i - 16), i == 128, 64, 16, 1);
    check("relocked", int'(locked), 1);

    // Chatter around MID on ch0.
    do_reset("rst_f");
    for (int i = 1; i <= 192; i++) begin
`ifdef SINE_MEAS_HYST_EN
      samp(chat(i), 8'h40, (i >= 128) && (i % 64 == 0), 64, 0, 0);
`else
      samp(chat(i), 8'h40,
           (i >= 23) && ((i % 64 == 0) || (i % 64 == 21) || (i % 64 == 23)),
           (i % 64 == 0) ? 41 : ((i % 64 == 21) ? 21 : 2), 0, 0);
`endif
    end

    // Reset in the middle of a period after lock.
    do_reset("rst_g");
    for (int i = 1; i <= 160; i++)
      samp(wave(i), wave(i - 16), i == 128, 64, 16, 1);
    check("locked_pre_reset", int'(locked), 1);
    do_reset("rst_mid");
    for (int i = 161; i <= 256; i++)
      samp(wave(i), wave(i - 16), i == 256, 64, 16, 1);

    repeat (4) step(1'b0, 8'h00, 8'h00);
    check("pending_valids", q.size(), 0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
